// File: rtl/op_issue_if.sv
// op_issue_if
//  Bundles every op_issue signal except clk/rst.
//  Groups:
//   - the instruction valid/ready handshake
//   - the combinational-read register file read and write ports
//   - the operand, operate and flag lines to the op_* units, and the result returned by them
//  Modports:
//   - master: the op_issue side
//   - slave:  the producer / register file / op-unit side
interface op_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        busy;
  logic [3:0]  rf_addr_a;
  logic [3:0]  rf_addr_b;
  logic [31:0] rf_data_a;
  logic [31:0] rf_data_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  op_sel;
  logic        en_inst;
  logic        IMM;
  logic        S;
  logic [31:0] Rn;
  logic [31:0] Rm;
  logic [11:0] imm_operand;
  logic [4:0]  imm_shift;
  logic [1:0]  stype;
  logic        carry_out;
  logic        zero_out;
  logic        neg_out;
  logic [31:0] op_rd;
  logic        op_carry;
  logic        op_zero;
  logic        op_neg;

  modport master (
    input  instr_valid, instr, rf_data_a, rf_data_b,
    input  op_rd, op_carry, op_zero, op_neg,
    output instr_ready, busy, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
    output op_sel, en_inst, IMM, S, Rn, Rm, imm_operand, imm_shift, stype,
    output carry_out, zero_out, neg_out
  );

  modport slave (
    output instr_valid, instr, rf_data_a, rf_data_b,
    output op_rd, op_carry, op_zero, op_neg,
    input  instr_ready, busy, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
    input  op_sel, en_inst, IMM, S, Rn, Rm, imm_operand, imm_shift, stype,
    input  carry_out, zero_out, neg_out
  );
endinterface

// File: rtl/op_issue.sv
// op_issue
//  Issue/writeback sequencer for ARM-format data-processing words.
//  Each accepted word walks through IDLE -> COND -> READ -> EXEC -> WB.
//   - COND checks the condition field against the NZCV flags; a failed condition returns to IDLE.
//   - READ fetches Rn/Rm from the register file.
//   - EXEC pulses en_inst to the op units for one cycle.
//   - WB writes Rd (except for the compare class) and updates N/Z/C when S is set.
//  Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : op_issue_if.master; carries the handshake, the register file ports, and the op-unit
//              operands, result and flags
//  Parameter:
//   RESET_FLAGS : {N,Z,C,V} value after reset
module op_issue #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic         clk,
  input  logic         rst,
  op_issue_if.master   bus
);

  typedef enum logic [2:0] {IDLE, COND, READ, EXEC, WB} state_t;

  state_t      state;
  logic [31:0] instr_q;
  logic [31:0] rn_q;
  logic [31:0] rm_q;
  logic [31:0] res_q;
  logic [2:0]  res_nzc_q;
  logic [3:0]  nzcv;
  logic        ready_q;
  logic        busy_q;
  logic        en_q;
  logic        we_q;

  logic        opnd_en;
  logic        cmp_class;
  logic        s_eff;
  logic        unused_bits;

  // Condition codes, evaluated against {N,Z,C,V}; 4'b1111 never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c & !z;
      4'h9:    cond_pass = !c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Opcodes 1000..1011 (TST/TEQ/CMP/CMN) only set flags: no Rd write, S forced on.
  assign cmp_class   = (instr_q[24:23] == 2'b10);
  assign s_eff       = instr_q[20] | cmp_class;
  assign opnd_en     = (state == READ) || (state == EXEC) || (state == WB);
  assign unused_bits = ^instr_q[27:26];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      instr_q   <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      res_q     <= '0;
      res_nzc_q <= '0;
      nzcv      <= RESET_FLAGS;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      case (state)
        // IDLE -> COND: latch the word on the handshake
        IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= COND;
          end
        end
        // COND -> READ or back to IDLE with no side effects
        COND: begin
          if (cond_pass(instr_q[31:28], nzcv)) begin
            state <= READ;
          end else begin
            instr_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        // READ -> EXEC: capture operands, raise the operate pulse
        READ: begin
          rn_q  <= bus.rf_data_a;
          rm_q  <= bus.rf_data_b;
          en_q  <= 1'b1;
          state <= EXEC;
        end
        // EXEC -> WB: capture the op unit result and flags
        EXEC: begin
          res_q     <= bus.op_rd;
          res_nzc_q <= {bus.op_neg, bus.op_zero, bus.op_carry};
          en_q      <= 1'b0;
          we_q      <= !cmp_class;
          state     <= WB;
        end
        // WB -> IDLE: commit flags, clear operand state
        WB: begin
          if (s_eff) begin
            nzcv[3:1] <= res_nzc_q;
          end
          we_q    <= 1'b0;
          instr_q <= '0;
          rn_q    <= '0;
          rm_q    <= '0;
          res_q   <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          en_q    <= 1'b0;
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.en_inst     = en_q;
  assign bus.rf_we       = we_q;
  assign bus.rf_waddr    = we_q ? instr_q[15:12] : 4'h0;
  assign bus.rf_wdata    = we_q ? res_q : 32'h0;
  assign bus.rf_addr_a   = (state == READ) ? instr_q[19:16] : 4'h0;
  assign bus.rf_addr_b   = (state == READ) ? instr_q[3:0] : 4'h0;

  // During READ the operands pass straight through from the register file, so Rn/Rm
  // already show their final values before the latches take them at the READ edge.
  assign bus.Rn          = (state == READ) ? bus.rf_data_a : rn_q;
  assign bus.Rm          = (state == READ) ? bus.rf_data_b : rm_q;

  assign bus.op_sel      = opnd_en ? instr_q[24:21] : 4'h0;
  assign bus.IMM         = opnd_en & instr_q[25];
  assign bus.S           = opnd_en & s_eff;
  assign bus.imm_operand = opnd_en ? instr_q[11:0] : 12'h0;
  assign bus.imm_shift   = opnd_en ? instr_q[11:7] : 5'h0;
  assign bus.stype       = opnd_en ? instr_q[6:5] : 2'h0;

  assign bus.neg_out     = nzcv[3];
  assign bus.zero_out    = nzcv[2];
  assign bus.carry_out   = nzcv[1];

endmodule

// File: tb/tb_op_issue.sv
module tb_op_issue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  op_issue_if bus();

  op_issue #(.RESET_FLAGS(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] regs [16];
  assign bus.rf_data_a = regs[bus.rf_addr_a];
  assign bus.rf_data_b = regs[bus.rf_addr_b];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents w for exactly one edge; caller is in IDLE, so that edge is the handshake.
  task automatic issue(input logic [31:0] w);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  // Runs one word until instr_ready returns (bounded), counting pulses seen.
  task automatic run(input logic [31:0] w, output int ticks, output int ens,
                     output int wes, output logic [31:0] wdata);
    issue(w);
    ticks = 0;
    ens   = int'(bus.en_inst);
    wes   = int'(bus.rf_we);
    wdata = 32'h0;
    while (!bus.instr_ready && ticks < 8) begin
      tick();
      ticks++;
      ens += int'(bus.en_inst);
      if (bus.rf_we) begin
        wes++;
        wdata = bus.rf_wdata;
      end
    end
  endtask

  int          n, ens, wes;
  logic [31:0] wd;
  logic [31:0] cap_rm, cap_sh, cap_st, cap_sel;

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.op_rd       = 32'h0;
    bus.op_carry    = 1'b0;
    bus.op_zero     = 1'b0;
    bus.op_neg      = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[1] = 32'hFFFF_FFFF;
    regs[2] = 32'h0000_0002;
    regs[3] = 32'h1111_1111;
    regs[5] = 32'h0000_0005;
    regs[6] = 32'h6666_6666;

    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", bus.instr_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_en", bus.en_inst, 0);
    check("rst_we", bus.rf_we, 0);
    check("rst_flags", {bus.neg_out, bus.zero_out, bus.carry_out}, 0);
    rst = 1'b0;
    tick();

    // 1: BIC R2,R1,#0xFF walked cycle by cycle; op_zero set to prove S=0 leaves flags alone
    bus.op_rd   = 32'hFFFF_FF00;
    bus.op_zero = 1'b1;
    issue(32'hE3C1_20FF);
    check("t1_cond_en", bus.en_inst, 0);
    check("t1_cond_ready", bus.instr_ready, 0);
    check("t1_cond_busy", bus.busy, 1);
    tick();
    check("t1_read_addr", bus.rf_addr_a, 1);
    check("t1_read_en", bus.en_inst, 0);
    tick();
    check("t1_exec_en", bus.en_inst, 1);
    check("t1_exec_rn", bus.Rn, 32'hFFFF_FFFF);
    check("t1_exec_imm", bus.IMM, 1);
    check("t1_exec_immop", bus.imm_operand, 32'h0FF);
    check("t1_exec_opsel", bus.op_sel, 4'hE);
    check("t1_exec_s", bus.S, 0);
    check("t1_exec_we", bus.rf_we, 0);
    tick();
    check("t1_wb_en", bus.en_inst, 0);
    check("t1_wb_we", bus.rf_we, 1);
    check("t1_wb_waddr", bus.rf_waddr, 2);
    check("t1_wb_wdata", bus.rf_wdata, 32'hFFFF_FF00);
    check("t1_wb_ready", bus.instr_ready, 0);
    tick();
    check("t1_idle_ready", bus.instr_ready, 1);
    check("t1_idle_we", bus.rf_we, 0);
    check("t1_idle_imm", bus.IMM, 0);
    check("t1_flags", {bus.neg_out, bus.zero_out, bus.carry_out}, 0);

    // 2: EQ with Z=0 fails in COND
    issue(32'h03C1_20FF);
    check("t2_cond_en", bus.en_inst, 0);
    tick();
    check("t2_ready", bus.instr_ready, 1);
    check("t2_en", bus.en_inst, 0);
    check("t2_we", bus.rf_we, 0);

    // 3: CMP R1,R2 sets Z and C, no write; V stays 0
    bus.op_rd    = 32'h1234_5678;
    bus.op_zero  = 1'b1;
    bus.op_carry = 1'b1;
    bus.op_neg   = 1'b0;
    run(32'hE151_0002, n, ens, wes, wd);
    check("t3_ticks", n, 4);
    check("t3_ens", ens, 1);
    check("t3_wes", wes, 0);
    check("t3_zero", bus.zero_out, 1);
    check("t3_carry", bus.carry_out, 1);
    check("t3_neg", bus.neg_out, 0);
    run(32'h63C1_20FF, n, ens, wes, wd);
    check("t3_vs_ticks", n, 1);
    check("t3_vs_ens", ens, 0);
    run(32'h73C1_20FF, n, ens, wes, wd);
    check("t3_vc_ens", ens, 1);
    run(32'h03C1_20FF, n, ens, wes, wd);
    check("t3_eq_ticks", n, 4);
    check("t3_eq_wes", wes, 1);

    // 4: reset during EXEC drops the instruction
    bus.op_rd = 32'hFFFF_FF00;
    issue(32'hE3C1_20FF);
    tick();
    tick();
    check("t4_exec_en", bus.en_inst, 1);
    rst = 1'b1;
    #1;
    check("t4_rst_en", bus.en_inst, 0);
    check("t4_rst_ready", bus.instr_ready, 1);
    check("t4_rst_busy", bus.busy, 0);
    check("t4_rst_rn", bus.Rn, 0);
    check("t4_rst_imm", bus.IMM, 0);
    check("t4_rst_opsel", bus.op_sel, 0);
    check("t4_rst_zero", bus.zero_out, 0);
    tick();
    check("t4_rst_we", bus.rf_we, 0);
    rst = 1'b0;
    tick();
    check("t4_after_we", bus.rf_we, 0);
    bus.op_rd = 32'hA5A5_A5A5;
    run(32'hE3C1_20FF, n, ens, wes, wd);
    check("t4_next_ticks", n, 4);
    check("t4_next_ens", ens, 1);
    check("t4_next_wes", wes, 1);
    check("t4_next_wdata", wd, 32'hA5A5_A5A5);

    // 5: back-to-back register-form words with valid held high
    bus.op_zero  = 1'b0;
    bus.op_carry = 1'b0;
    cap_rm = 0; cap_sh = 0; cap_st = 0; cap_sel = 0;
    bus.instr       = 32'hE083_42C5;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr = 32'hE083_7FA6;
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      tick();
      n++;
      if (bus.en_inst) begin
        cap_rm = bus.Rm; cap_sh = 32'(bus.imm_shift); cap_st = 32'(bus.stype);
      end
    end
    check("t5a_rm", cap_rm, 32'h0000_0005);
    check("t5a_shift", cap_sh, 5);
    check("t5a_stype", cap_st, 2);
    tick();
    check("t5_spacing", n + 1, 5);
    check("t5_accept_busy", bus.busy, 1);
    bus.instr_valid = 1'b0;
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      tick();
      n++;
      if (bus.en_inst) begin
        cap_rm = bus.Rm; cap_sh = 32'(bus.imm_shift); cap_st = 32'(bus.stype);
        cap_sel = {27'h0, bus.S, bus.op_sel};
      end
    end
    check("t5b_rm", cap_rm, 32'h6666_6666);
    check("t5b_shift", cap_sh, 32'h1F);
    check("t5b_stype", cap_st, 1);
    check("t5b_s_opsel", cap_sel, 32'h04);
    tick();
    check("t5_no_extra", bus.busy, 0);

    // 6: cond 1111 never runs, 1110 always runs, across all N/Z/C combinations
    for (int f = 0; f < 8; f++) begin
      bus.op_neg   = f[2];
      bus.op_zero  = f[1];
      bus.op_carry = f[0];
      run(32'hE151_0002, n, ens, wes, wd);
      check($sformatf("t6_flags_%0d", f), {bus.neg_out, bus.zero_out, bus.carry_out}, 32'(f));
      run(32'hF3C1_20FF, n, ens, wes, wd);
      check($sformatf("t6_nv_ens_%0d", f), ens, 0);
      check($sformatf("t6_nv_ticks_%0d", f), n, 1);
      run(32'hE3C1_20FF, n, ens, wes, wd);
      check($sformatf("t6_al_ens_%0d", f), ens, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
